// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/retire controller: widths, divide-class
// operation bits, FSM state encoding and the divide classification helper.
package alu_issue_ctrl_pkg;

   localparam int ALU_OP_W = 19;
   localparam int TAG_W    = 5;
   localparam int DIV_LO   = 15;
   localparam int DIV_HI   = 18;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      DIV_ARM,
      DIV_BUSY,
      DRAIN
   } state_t;

   // A divide-class op with a zero divisor resolves in one cycle in the ALU.
   function automatic logic is_div(input logic [ALU_OP_W-1:0] op,
                                   input logic [31:0]         src2);
      return (|op[DIV_HI:DIV_LO]) && (src2 != 32'd0);
   endfunction

endpackage

// File: rtl/issue_skid_buf.sv
// One-entry skid register in front of the issue slot. Provides a registered
// in_ready and presents the next operation (skid first, then input) as the head.
module issue_skid_buf
   import alu_issue_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] in_alu_op,
   input  logic [31:0]         in_src1,
   input  logic [31:0]         in_src2,
   input  logic [TAG_W-1:0]    in_tag,
   input  logic                issue_free,
   input  logic                hold_next,
   output logic                head_valid,
   output logic [ALU_OP_W-1:0] head_op,
   output logic [31:0]         head_src1,
   output logic [31:0]         head_src2,
   output logic [TAG_W-1:0]    head_tag
);

   logic                skid_valid;
   logic [ALU_OP_W-1:0] skid_op;
   logic [31:0]         skid_src1;
   logic [31:0]         skid_src2;
   logic [TAG_W-1:0]    skid_tag;
   logic                accept;
   logic                skid_load;
   logic                skid_valid_next;

   assign accept    = in_valid & in_ready & ~flush;
   assign skid_load = accept & ~issue_free;

   // While the skid holds an entry in_ready is low, so it is always the head.
   always_comb begin
      head_valid = skid_valid | accept;
      head_op    = skid_valid ? skid_op   : in_alu_op;
      head_src1  = skid_valid ? skid_src1 : in_src1;
      head_src2  = skid_valid ? skid_src2 : in_src2;
      head_tag   = skid_valid ? skid_tag  : in_tag;
   end

   always_comb begin
      skid_valid_next = 1'b0;
      if (flush)
         skid_valid_next = 1'b0;
      else if (skid_valid)
         skid_valid_next = ~issue_free;
      else
         skid_valid_next = skid_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         skid_op    <= '0;
         skid_src1  <= '0;
         skid_src2  <= '0;
         skid_tag   <= '0;
      end else begin
         skid_valid <= skid_valid_next;
         in_ready   <= ~skid_valid_next & ~hold_next;
         if (skid_load) begin
            skid_op   <= in_alu_op;
            skid_src1 <= in_src1;
            skid_src2 <= in_src2;
            skid_tag  <= in_tag;
         end
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller in front of the execute ALU: holds operands for the
// whole operation (including multi-cycle divides) and owns the result slot.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] in_alu_op,
   input  logic [31:0]         in_src1,
   input  logic [31:0]         in_src2,
   input  logic [TAG_W-1:0]    in_tag,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [31:0]         alu_src1,
   output logic [31:0]         alu_src2,
   input  logic                div_stall,
   input  logic [31:0]         alu_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_result,
   output logic [TAG_W-1:0]    out_tag
);

   state_t              state;
   state_t              state_next;
   logic [TAG_W-1:0]    issue_tag;
   logic                cur_div;
   logic                capture_ok;
   logic                cap;
   logic                issue_free;
   logic                hold_next;
   logic                head_valid;
   logic [ALU_OP_W-1:0] head_op;
   logic [31:0]         head_src1;
   logic [31:0]         head_src2;
   logic [TAG_W-1:0]    head_tag;

   assign cur_div    = is_div(alu_op, alu_src2);
   assign capture_ok = ~out_valid | out_ready;
   assign hold_next  = (state_next == DRAIN);

   issue_skid_buf u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_alu_op  (in_alu_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_tag     (in_tag),
      .issue_free (issue_free),
      .hold_next  (hold_next),
      .head_valid (head_valid),
      .head_op    (head_op),
      .head_src1  (head_src1),
      .head_src2  (head_src2),
      .head_tag   (head_tag)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A flushed divide keeps the ALU busy, so we wait it out in DRAIN.
   always_comb begin
      state_next = state;
      if (flush && (state == DIV_ARM || state == DIV_BUSY)) begin
         state_next = DRAIN;
      end else if (flush && state != DRAIN) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:     if (head_valid) state_next = EXEC;
            EXEC: begin
               if (cur_div)
                  state_next = DIV_ARM;
               else if (capture_ok)
                  state_next = head_valid ? EXEC : IDLE;
            end
            DIV_ARM:  state_next = DIV_BUSY;
            DIV_BUSY: begin
               if (!div_stall && capture_ok)
                  state_next = head_valid ? EXEC : IDLE;
            end
            DRAIN:    if (!div_stall) state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      cap = 1'b0;
      case (state)
         EXEC:     cap = ~flush & ~cur_div & capture_ok;
         DIV_BUSY: cap = ~flush & ~div_stall & capture_ok;
         default:  cap = 1'b0;
      endcase
      issue_free = ((state == IDLE) & ~flush) | cap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_op    <= '0;
         alu_src1  <= '0;
         alu_src2  <= '0;
         issue_tag <= '0;
      end else if (flush) begin
         alu_op <= '0;
      end else if (issue_free) begin
         if (head_valid) begin
            alu_op    <= head_op;
            alu_src1  <= head_src1;
            alu_src2  <= head_src2;
            issue_tag <= head_tag;
         end else begin
            alu_op <= '0;
         end
      end
   end

   // Capture and release may coincide, giving one result per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (cap) begin
         out_valid  <= 1'b1;
         out_result <= alu_result;
         out_tag    <= issue_tag;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a result
// scoreboard checked by an independent monitor.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam logic [ALU_OP_W-1:0] OP_ADD = 19'h00001;
   localparam logic [ALU_OP_W-1:0] OP_SUB = 19'h00002;
   localparam logic [ALU_OP_W-1:0] OP_AND = 19'h00004;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 19'h00008;
   localparam logic [ALU_OP_W-1:0] OP_XOR = 19'h00010;
   localparam logic [ALU_OP_W-1:0] OP_DIV = 19'h08000;

   typedef struct packed {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [ALU_OP_W-1:0] in_alu_op;
   logic [31:0]         in_src1;
   logic [31:0]         in_src2;
   logic [TAG_W-1:0]    in_tag;
   logic [ALU_OP_W-1:0] alu_op;
   logic [31:0]         alu_src1;
   logic [31:0]         alu_src2;
   logic                div_stall;
   logic [31:0]         alu_result;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_result;
   logic [TAG_W-1:0]    out_tag;

   exp_t sb[$];
   int   pop_cycles[$];
   int   cyc = 0;
   int   pass_cnt = 0;
   int   check_cnt = 0;

   alu_issue_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_alu_op  (in_alu_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_tag     (in_tag),
      .alu_op     (alu_op),
      .alu_src1   (alu_src1),
      .alu_src2   (alu_src2),
      .div_stall  (div_stall),
      .alu_result (alu_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU; division by zero returns all ones.
   always_comb begin
      alu_result = 32'd0;
      if (alu_op[0])       alu_result = alu_src1 + alu_src2;
      else if (alu_op[1])  alu_result = alu_src1 - alu_src2;
      else if (alu_op[2])  alu_result = alu_src1 & alu_src2;
      else if (alu_op[3])  alu_result = alu_src1 | alu_src2;
      else if (alu_op[4])  alu_result = alu_src1 ^ alu_src2;
      else if (alu_op[15]) alu_result = (alu_src2 == 32'd0) ? 32'hFFFF_FFFF
                                        : 32'($signed(alu_src1) / $signed(alu_src2));
   end

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      check_cnt++;
      if (act === req) pass_cnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic checkOutput();
      exp_t e;
      check_cnt++;
      pop_cycles.push_back(cyc);
      if (sb.size() == 0) begin
         $display("[TB] FAIL unexpected_result: got %h tag %0d, expected none", out_result, out_tag);
         return;
      end
      e = sb.pop_front();
      if (out_result === e.res && out_tag === e.tag) pass_cnt++;
      else $display("[TB] FAIL result: got %h tag %0d, expected %h tag %0d",
                    out_result, out_tag, e.res, e.tag);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) checkOutput();
   end

   // Offers one op and returns just after the edge where it was accepted.
   task automatic applyStimulus(input logic [ALU_OP_W-1:0] op, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [TAG_W-1:0] tag,
                                input logic [31:0] exp_res, input bit push);
      logic rdy;
      in_valid  = 1'b1;
      in_alu_op = op;
      in_src1   = s1;
      in_src2   = s2;
      in_tag    = tag;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            if (push) sb.push_back('{res: exp_res, tag: tag});
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      check_cnt++;
      $display("[TB] FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) return;
         stepCycle();
      end
      check_cnt++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  idx;
      bit  ok;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alu_op = '0;
      in_src1 = '0; in_src2 = '0; in_tag = '0; div_stall = 1'b0; out_ready = 1'b1;
      repeat (3) stepCycle();
      rst = 1'b0;
      $display("[TB] reset checks");
      checkValue("rst_in_ready", 32'(in_ready), 32'd1);
      checkValue("rst_out_valid", 32'(out_valid), 32'd0);
      checkValue("rst_alu_op", 32'(alu_op), 32'd0);
      checkValue("rst_alu_src1", alu_src1, 32'd0);
      checkValue("rst_out_result", out_result, 32'd0);
      checkValue("rst_out_tag", 32'(out_tag), 32'd0);

      $display("[TB] single add");
      applyStimulus(OP_ADD, 32'd5, 32'd7, 5'd1, 32'd12, 1'b1);
      checkValue("add_in_ready", 32'(in_ready), 32'd1);
      stepCycle();
      checkValue("add_latency_out_valid", 32'(out_valid), 32'd1);
      waitDrain();
      stepCycle();

      $display("[TB] back-to-back");
      idx = pop_cycles.size();
      applyStimulus(OP_ADD, 32'd5, 32'd7, 5'd2, 32'h0000_000C, 1'b1);
      applyStimulus(OP_SUB, 32'd3, 32'd5, 5'd3, 32'hFFFF_FFFE, 1'b1);
      applyStimulus(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd4, 32'h00F0_000F, 1'b1);
      applyStimulus(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd5, 32'h5555_5555, 1'b1);
      waitDrain();
      stepCycle();
      checkValue("b2b_count", 32'(pop_cycles.size() - idx), 32'd4);
      if (pop_cycles.size() - idx == 4)
         checkValue("b2b_no_bubble", 32'(pop_cycles[idx+3] - pop_cycles[idx]), 32'd3);

      $display("[TB] divide with stall");
      div_stall = 1'b1;
      applyStimulus(OP_DIV, 32'd100, 32'd7, 5'd6, 32'd14, 1'b1);
      applyStimulus(OP_ADD, 32'd2, 32'd3, 5'd7, 32'd5, 1'b1);
      checkValue("div_skid_in_ready", 32'(in_ready), 32'd0);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         stepCycle();
         if (alu_src1 !== 32'd100 || alu_src2 !== 32'd7 || alu_op !== OP_DIV ||
             out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
      end
      checkValue("div_operands_stable", 32'(ok), 32'd1);
      div_stall = 1'b0;
      stepCycle();
      checkValue("div_capture_valid", 32'(out_valid), 32'd1);
      checkValue("div_capture_result", out_result, 32'd14);
      waitDrain();
      stepCycle();

      $display("[TB] divide by zero");
      applyStimulus(OP_DIV, 32'd9, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b1);
      stepCycle();
      checkValue("div0_latency_out_valid", 32'(out_valid), 32'd1);
      waitDrain();
      stepCycle();

      $display("[TB] output backpressure");
      out_ready = 1'b0;
      applyStimulus(OP_OR,  32'h1234_0000, 32'h0000_5678, 5'd9,  32'h1234_5678, 1'b1);
      applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1,         5'd10, 32'd0,        1'b1);
      applyStimulus(OP_AND, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, 32'h8000_0001, 1'b1);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         if (out_result !== 32'h1234_5678 || out_tag !== 5'd9 || out_valid !== 1'b1 ||
             in_ready !== 1'b0) ok = 1'b0;
      end
      checkValue("bp_hold_stable", 32'(ok), 32'd1);
      out_ready = 1'b1;
      waitDrain();
      stepCycle();

      $display("[TB] flush during divide");
      out_ready = 1'b0;
      div_stall = 1'b1;
      applyStimulus(OP_ADD, 32'd4, 32'd4, 5'd12, 32'd8, 1'b0);
      applyStimulus(OP_DIV, 32'd50, 32'd5, 5'd13, 32'd10, 1'b0);
      stepCycle();
      stepCycle();
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_alu_op = OP_ADD;
      in_src1   = 32'd77;
      in_src2   = 32'd77;
      in_tag    = 5'd14;
      stepCycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      checkValue("flush_out_valid", 32'(out_valid), 32'd0);
      checkValue("flush_alu_op", 32'(alu_op), 32'd0);
      checkValue("flush_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         if (in_ready !== 1'b0 || alu_op !== '0 || out_valid !== 1'b0) ok = 1'b0;
      end
      checkValue("drain_hold", 32'(ok), 32'd1);
      div_stall = 1'b0;
      stepCycle();
      checkValue("drain_exit_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(OP_ADD, 32'd1, 32'd1, 5'd15, 32'd2, 1'b1);
      waitDrain();
      repeat (3) stepCycle();
      checkValue("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/retire controller that sits directly upstream of the execute ALU.
- Accepts decoded operations from the decode stage via valid/ready and holds the ALU operands stable for the whole execution, including multi-cycle divides signalled by div_stall.
- Captures the ALU result into a registered output slot with its own valid/ready handshake toward the memory stage.
- Owns flush handling and drains an in-flight divide so a killed divide cannot corrupt the next operation.

Parameters:
- ALU_OP_W, 19, width of the one-hot ALU operation vector (bit 15..18 = div, mod, divu, modu).
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill all held and in-flight operations; synchronous.
- in_valid  in  1  decode offers an operation.
- in_ready  out  1  block can accept; registered.
- in_alu_op  in  ALU_OP_W  one-hot operation.
- in_src1  in  32  operand 1.
- in_src2  in  32  operand 2.
- in_tag  in  TAG_W  destination tag.
- alu_op  out  ALU_OP_W  operation driven to the ALU; all-zero when no operation is held.
- alu_src1  out  32  operand 1 to the ALU.
- alu_src2  out  32  operand 2 to the ALU.
- div_stall  in  1  ALU divider busy (high = result not ready).
- alu_result  in  32  ALU combinational result.
- out_valid  out  1  result slot holds a result.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  captured result.
- out_tag  out  TAG_W  tag of the captured result.

Behaviour:
- Reset values: in_ready=1; out_valid=0; alu_op=0; alu_src1=alu_src2=0; out_result=0; out_tag=0; FSM=IDLE; skid empty.
- Storage:
  - Issue slot: op, src1, src2, tag; drives the alu_* ports directly from flops.
  - One-entry skid buffer.
  - Output slot.
- in_ready = ~skid_valid, registered.
- Input transfer when in_valid & in_ready:
  - If the issue slot will be free at that edge, the operation loads the issue slot.
  - Otherwise it loads the skid buffer.
  - On the next free issue slot, skid contents move in first (FIFO order preserved).
- An operation is a divide when any of alu_op[18:15] is set and src2 != 0. Any divide-class op with src2 == 0 is treated as single-cycle.
- FSM:
  - IDLE: issue slot empty. A load moves to EXEC.
  - EXEC:
    - Non-divide with the output slot free (or out_ready this cycle): capture alu_result/tag into the output slot at this edge (1-cycle latency from issue). Then load the next op (EXEC) or go to IDLE.
    - Non-divide with the output slot blocked: stay in EXEC, operands held.
    - Divide: go to DIV_ARM.
  - DIV_ARM: one cycle; div_stall is ignored. Go to DIV_BUSY.
  - DIV_BUSY: stay while div_stall=1. When div_stall=0 and the output slot is free, capture and leave as in EXEC. Operands must stay unchanged throughout DIV_ARM and DIV_BUSY.
  - DRAIN: entered on flush from DIV_ARM or DIV_BUSY. alu_op=0. Hold while div_stall=1, then go to IDLE. in_ready=0 in DRAIN.
- Output slot:
  - out_valid is set on capture and cleared on out_valid & out_ready.
  - Simultaneous release and capture at the same edge is allowed (back-to-back single-cycle ops give 1 result per cycle).
  - out_result and out_tag are held stable while out_valid & ~out_ready.
- Flush:
  - Clears the issue slot, skid buffer and output slot.
  - Goes to IDLE, or to DRAIN if a divide is in flight.
  - An input handshake in the same cycle as flush is discarded.
  - Flush has priority over capture.
- rst has priority over flush. rst mid-divide goes to IDLE; the ALU is reset by the same rst.
- Throughput: 1 op/cycle for single-cycle ops. A divide occupies the slot for ≥2 cycles plus the div_stall duration.

Decomposition:
- Shared package/header (existing defines file):
  - ALU_OP_W.
  - Div-class bit indices (15–18).
  - FSM state encodings: IDLE, EXEC, DIV_ARM, DIV_BUSY, DRAIN.
- One natural sub-module: issue_skid_buf (1-entry skid register providing registered in_ready). The FSM and output slot stay in the top.

Test Plan:
- Reset, then add 5+7 with out_ready=1 → out_valid one cycle after the input handshake; out_result=12; in_ready=1 throughout.
- Four back-to-back ops (add, sub 3−5, and, xor) with out_ready=1 → 4 results on consecutive cycles: 0x0000000C…, 0xFFFFFFFE, …; no bubbles.
- div 100/7, div_stall held high 10 cycles → alu_src1/alu_src2 stable for the whole divide; out_result=14 captured the cycle div_stall drops; a following add is held in the skid buffer and in_ready=0 after 2 accepts.
- div with src2=0 → treated as single-cycle; captured at 1-cycle latency; no DIV_ARM entry.
- out_ready=0 for 5 cycles with 3 ops offered → out_result held; issue slot and skid fill; in_ready=0; all 3 results emerge in order once out_ready=1.
- flush during DIV_BUSY (div_stall still high 4 more cycles) → out_valid=0; alu_op=0; in_ready=0 until div_stall low; then a new add 1+1 yields 2.
